// File: rtl/prienc_pkg.sv
// Shared types and helpers for the priority arbiter/encoder block.
package prienc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/pe_lsb.sv
// Combinational lowest-set-bit encoder: idx of the lowest asserted bit, found if any.
module pe_lsb
  import prienc_pkg::*;
#(
  parameter int unsigned N = 10
) (
  input  logic [N-1:0]          req,
  output logic                  found,
  output logic [clog2(N)-1:0]   idx
);

  localparam int unsigned IW = clog2(N);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/priority_arbiter_enc.sv
// Registered fixed/round-robin priority arbiter with valid/ready result handshake.
// Optional registered one-hot grant output under PRIENC_GRANT_ONEHOT_EN.
module priority_arbiter_enc
  import prienc_pkg::*;
#(
  parameter int unsigned N  = 10,
  parameter int unsigned IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          mode,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [IW-1:0] out_idx
`ifdef PRIENC_GRANT_ONEHOT_EN
  ,
  output logic [N-1:0]  grant
`endif
);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          mode_q, mode_d;

  logic          accept_c;
  logic          load_c;
  logic [IW-1:0] ptr_inc_c;
  logic [IW-1:0] search_ptr_c;
  logic [IW-1:0] eff_ptr_c;
  logic [N-1:0]  req_masked_c;
  logic          found_m, found_r;
  logic [IW-1:0] idx_m, idx_r;
  logic [IW-1:0] winner_c;

  assign accept_c  = (state_q == HOLD) && out_ready;
  assign load_c    = (state_q == IDLE) || out_ready;
  assign ptr_inc_c = (32'(out_idx) == N - 1) ? '0 : out_idx + IW'(1);

  // The pointer advances on this very accept, so the new winner must already see it.
  assign search_ptr_c = (accept_c && mode_q == MODE_RR) ? ptr_inc_c : ptr_q;
  assign eff_ptr_c    = (32'(search_ptr_c) >= N) ? '0 : search_ptr_c;

  always_comb begin
    req_masked_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_masked_c[i] = req[i] && (i >= 32'(eff_ptr_c));
    end
  end

  pe_lsb #(.N(N)) u_pe_masked (
    .req   (req_masked_c),
    .found (found_m),
    .idx   (idx_m)
  );

  pe_lsb #(.N(N)) u_pe_raw (
    .req   (req),
    .found (found_r),
    .idx   (idx_r)
  );

  assign winner_c = (mode == MODE_RR && found_m) ? idx_m : idx_r;

  // Next-state and next-result logic.
  always_comb begin
    state_d = state_q;
    idx_d   = out_idx;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    if (accept_c && mode_q == MODE_RR) begin
      ptr_d = ptr_inc_c;
    end
    if (load_c) begin
      mode_d = mode;
      if (found_r) begin
        state_d = HOLD;
        idx_d   = winner_c;
      end else begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_idx <= '0;
      ptr_q   <= '0;
      mode_q  <= MODE_FIXED;
    end else begin
      state_q <= state_d;
      out_idx <= idx_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
    end
  end

  assign out_valid = (state_q == HOLD);

`ifdef PRIENC_GRANT_ONEHOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
    end else begin
      grant <= (state_d == HOLD) ? (N'(1) << idx_d) : '0;
    end
  end
`endif

endmodule

// File: tb/tb_priority_arbiter_enc.sv
// Directed self-checking bench for priority_arbiter_enc (N=10); grant checked under PRIENC_GRANT_ONEHOT_EN.
module tb_priority_arbiter_enc;

  localparam int unsigned N  = 10;
  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic          mode;
  logic          out_ready;
  logic          out_valid;
  logic [IW-1:0] out_idx;
`ifdef PRIENC_GRANT_ONEHOT_EN
  logic [N-1:0]  grant;
`endif

  int n_asrt;
  int n_fail;

  priority_arbiter_enc #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx)
`ifdef PRIENC_GRANT_ONEHOT_EN
    ,
    .grant     (grant)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic v, input int unsigned idx);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".idx"}, 64'(out_idx), 64'(idx));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    clk = 1'b0;
    rst = 1'b1;
    req = '0;
    mode = 1'b0;
    out_ready = 1'b0;
    #12;
    chk_res("reset", 1'b0, 0);
`ifdef PRIENC_GRANT_ONEHOT_EN
    chk("reset.grant", 64'(grant), 64'h0);
`endif
    rst = 1'b0;

    // Fixed priority: lowest set index wins, one-cycle latency
    req = 10'b10_0000_1000; out_ready = 1'b1; mode = 1'b0;
    tick(); chk_res("fixed_load", 1'b1, 3);
    req = '0;
    tick(); chk_res("fixed_drop", 1'b0, 0);
    tick(); chk_res("idle_stay", 1'b0, 0);

    // Backpressure: result holds while out_ready=0 regardless of req
    req = 10'b10_0000_1000;
    tick(); chk_res("bp_load", 1'b1, 3);
    out_ready = 1'b0; req = 10'h001;
    for (int k = 0; k < 3; k++) begin
      tick(); chk_res("bp_hold", 1'b1, 3);
    end
    out_ready = 1'b1;
    tick(); chk_res("bp_accept", 1'b1, 0);
    req = '0;
    tick(); chk_res("bp_idle", 1'b0, 0);

    // Round-robin full request: 0..9 then wrap
    mode = 1'b1; req = 10'h3FF;
    for (int k = 0; k < 12; k++) begin
      tick(); chk_res("rr_seq", 1'b1, k % 10);
`ifdef PRIENC_GRANT_ONEHOT_EN
      if (k == 9) chk("rr_grant9", 64'(grant), 64'h200);
`endif
    end
    for (int k = 2; k < 8; k++) begin
      tick(); chk_res("rr_seq2", 1'b1, k);
    end

    // ptr becomes 8 on this accept; no request >= 8 so wrap to lowest
    req = 10'h005;
    tick(); chk_res("rr_wrap0", 1'b1, 0);
    tick(); chk_res("rr_wrap2", 1'b1, 2);

    // Reset mid-HOLD must clear immediately and restart ptr at 0
    req = 10'h020;
    tick(); chk_res("rr_load5", 1'b1, 5);
    out_ready = 1'b0; req = 10'h3FF;
    tick(); chk_res("rr_hold5", 1'b1, 5);
    #2; rst = 1'b1;
    #1; chk_res("async_rst", 1'b0, 0);
`ifdef PRIENC_GRANT_ONEHOT_EN
    chk("async_rst.grant", 64'(grant), 64'h0);
`endif
    #2; rst = 1'b0;
    out_ready = 1'b1; req = 10'h3FF; mode = 1'b1;
    tick(); chk_res("post_rst", 1'b1, 0);

    // Mode change during HOLD only applies at the next load
    out_ready = 1'b0; mode = 1'b0;
    tick(); chk_res("mode_hold", 1'b1, 0);
    out_ready = 1'b1;
    tick(); chk_res("mode_fixed", 1'b1, 0);
    mode = 1'b1;
    tick(); chk_res("mode_rr1", 1'b1, 1);
    tick(); chk_res("mode_rr2", 1'b1, 2);
`ifdef PRIENC_GRANT_ONEHOT_EN
    chk("grant2", 64'(grant), 64'h004);
`endif
    req = '0;
    tick(); chk_res("final_idle", 1'b0, 0);
`ifdef PRIENC_GRANT_ONEHOT_EN
    chk("final_idle.grant", 64'(grant), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_arbiter_enc.md
PRIORITY_ARBITER_ENC -- requirements
Module: priority_arbiter_enc

Interface
- REQ-001 Parameter: N, 10, number of request lines; legal range 2..64.
- REQ-002 Parameter: IW, clog2(N), width of the encoded index output.
- REQ-003 Port: clk  input  1  single clock, rising edge.
- REQ-004 Port: rst  input  1  asynchronous, active-high reset.
- REQ-005 Port: req  input  N  request vector; bit i asserts request i.
- REQ-006 Port: mode  input  1  0 = fixed priority (index 0 highest), 1 = round-robin.
- REQ-007 Port: out_ready  input  1  consumer accepts the current result.
- REQ-008 Port: out_valid  output  1  registered result valid.
- REQ-009 Port: out_idx  output  IW  encoded winning request index.
- REQ-010 Port: grant  output  N  one-hot grant; exists only under PRIENC_GRANT_ONEHOT_EN.

Function
- REQ-011 The block SHALL have two states, IDLE (out_valid=0) and HOLD (out_valid=1), both registered.
- REQ-012 In IDLE with req nonzero, the block SHALL load the winner into out_idx and enter HOLD on the next clk edge (latency 1 cycle).
- REQ-013 In IDLE with req zero, the block SHALL stay in IDLE with out_idx = 0 (never X).
- REQ-014 In HOLD with out_ready=0, out_idx SHALL hold stable, and req and mode changes SHALL be ignored.
- REQ-015 In HOLD with out_ready=1 (accept), the block SHALL load a new winner and stay in HOLD when req is nonzero that cycle, else it SHALL go to IDLE with out_idx = 0; back-to-back accepts SHALL sustain one result per cycle.
- REQ-016 Fixed mode: the winner SHALL be the lowest set index of req.
- REQ-017 Round-robin mode: the winner SHALL be the lowest set index >= ptr; if none exists, it SHALL be the lowest set index overall.
- REQ-018 ptr (IW bits) SHALL update only on accept in round-robin mode, to out_idx+1, wrapping to 0 when out_idx = N-1; otherwise ptr SHALL hold.
- REQ-019 mode SHALL be sampled only at a load; a mode change while in HOLD SHALL take effect at the next load.
- REQ-020 ptr values >= N cannot occur; the winner logic SHALL treat any such value as 0.

Reset
- REQ-021 While rst=1, the block SHALL asynchronously force state IDLE, out_valid=0, out_idx=0, ptr=0 and grant=0.
- REQ-022 Reset asserted in HOLD SHALL drop the result without an accept, and the first load after release SHALL use ptr=0.

Configuration
- REQ-023 With PRIENC_GRANT_ONEHOT_EN defined, port grant SHALL exist, registered, equal to 1<<out_idx while out_valid=1 and 0 otherwise.
- REQ-024 Without PRIENC_GRANT_ONEHOT_EN, port grant and its register SHALL be absent, with all other behaviour unchanged.

Structure
- REQ-025 Package prienc_pkg SHALL hold: the MODE_FIXED/MODE_RR constants, the state enum typedef (IDLE/HOLD), and the clog2 function.
- REQ-026 Sub-module pe_lsb (combinational lowest-set-bit encoder, parameter N, outputs found and idx) SHALL be instantiated twice in priority_arbiter_enc: once on req masked by ptr, once on raw req.

Verification (N=10)
- REQ-027 Fixed mode, req=10'b10_0000_1000, out_ready=1: one cycle later out_valid=1 and out_idx=3; when req drops to 0, out_valid=0 and out_idx=0 the cycle after.
- REQ-028 Backpressure: after out_idx=3 is loaded, hold out_ready=0 for 3 cycles with req changed to 10'h001: out_idx stays 3; on out_ready=1, out_idx becomes 0 the next cycle.
- REQ-029 Round-robin, req=10'h3FF, out_ready=1 continuously: out_idx sequence is 0,1,...,9,0,1, one per cycle.
- REQ-030 Round-robin wrap: with ptr=8 and req=10'h005, out_idx=0 and ptr becomes 1; next winner is 2.
- REQ-031 Reset mid-HOLD (out_idx=5, round-robin, ptr=6): rst pulse clears out_valid, out_idx and ptr immediately; with req=10'h3FF after release, first out_idx=0.
- REQ-032 With PRIENC_GRANT_ONEHOT_EN, out_idx=9 valid gives grant=10'b10_0000_0000; grant=0 in IDLE.
